// File: rtl/demux_1xn_stream.sv
// 1-to-N stream demultiplexer with packet lock and per-channel output registers.
// Optional sticky out-of-range flag: define DEMUX_1XN_ERR_EN.
module demux_1xn_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_last,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t             state_q, state_d;
    logic [SELW-1:0]    cur_sel_q, cur_sel_d;
    logic [N*WIDTH-1:0] data_q, data_d;
    logic [N-1:0]       last_q, last_d;
    logic [N-1:0]       valid_q, valid_d;

    logic [SELW-1:0]    tgt;
    logic [N-1:0]       hit;
    logic               acc;

    // One-hot target; an out-of-range target matches no channel.
    always_comb begin
        tgt = (state_q == LOCK) ? cur_sel_q : in_sel;
        hit = '0;
        for (int k = 0; k < N; k++) begin
            hit[k] = (tgt == SELW'(k));
        end
    end

    assign in_ready = ~|(hit & valid_q & ~out_ready);
    assign acc      = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        unique case (state_q)
            IDLE: begin
                if (acc && !in_last) begin
                    state_d   = LOCK;
                    cur_sel_d = in_sel;
                end
            end
            LOCK: begin
                if (acc && in_last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Drain first, then a load on the same channel overrides it.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q & ~out_ready;
        for (int k = 0; k < N; k++) begin
            if (acc && hit[k]) begin
                data_d[k*WIDTH +: WIDTH] = in_data;
                last_d[k]                = in_last;
                valid_d[k]               = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            data_q    <= '0;
            last_q    <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            data_q    <= data_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == LOCK);

`ifdef DEMUX_1XN_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (acc & ~|hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/demux_1xn_stream.md
DEMUX_1XN_STREAM -- requirements
Module: demux_1xn_stream

Interface
REQ-001 Parameter WIDTH, default 8: payload bits per beat.
REQ-002 Parameter N, default 8: output channel count, legal range 2..16.
REQ-003 Parameter SELW, default 3: select width; N <= 2**SELW.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  WIDTH  payload of the input beat.
REQ-007 in_sel  input  SELW  target channel index for the beat.
REQ-008 in_last  input  1  marks the final beat of a packet.
REQ-009 in_valid  input  1  input beat offered.
REQ-010 in_ready  output  1  input beat accepted when in_valid and in_ready are both high.
REQ-011 out_data  output  N*WIDTH  channel k payload in bits [k*WIDTH +: WIDTH].
REQ-012 out_last  output  N  per-channel last flag.
REQ-013 out_valid  output  N  per-channel beat valid.
REQ-014 out_ready  input  N  per-channel sink ready.
REQ-015 busy  output  1  high while the FSM is in LOCK.
REQ-016 err  output  1  sticky out-of-range select flag.

Function
REQ-017 Each channel SHALL have a one-entry output register holding {data, last, valid}; a beat transfers out when out_valid[k] & out_ready[k].
REQ-018 The FSM SHALL have two states: IDLE and LOCK.
REQ-019 IDLE: routing uses in_sel; an accepted beat with in_last=0 latches in_sel into cur_sel -> LOCK; an accepted beat with in_last=1 stays in IDLE.
REQ-020 LOCK: routing uses cur_sel and in_sel is ignored; an accepted beat with in_last=1 -> IDLE.
REQ-021 Target t = in_sel in IDLE, cur_sel in LOCK.
REQ-022 in_ready SHALL equal (t >= N) | ~out_valid[t] | out_ready[t], purely combinational; full-throughput pass-through when the sink is ready.
REQ-023 An accepted beat with t < N SHALL load channel t's register on the same edge; out_valid[t] rises the next cycle (latency 1).
REQ-024 Simultaneous drain and load on channel t SHALL replace the register contents and keep out_valid[t]=1.
REQ-025 Channels other than t SHALL be unaffected by the beat; each independently clears valid when drained.
REQ-026 out_data/out_last SHALL hold their last value after valid drops.
REQ-027 Beats with t >= N SHALL be accepted (in_ready=1) and discarded; FSM transitions still apply, so a whole out-of-range packet is dropped.
REQ-028 No beat SHALL be duplicated or lost for in-range targets.

Reset
REQ-029 While rst=1: FSM=IDLE, cur_sel=0, all out_valid=0, out_last=0, out_data=0, err=0, busy=0, independent of clk.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; after release the next accepted beat is treated as a packet start.

Configuration
REQ-031 Macro DEMUX_1XN_ERR_EN: when defined, err SHALL set on the cycle after an accepted beat with t >= N and stay set until rst.
REQ-032 Without DEMUX_1XN_ERR_EN, err SHALL be tied to 0 and out-of-range beats are still silently dropped per REQ-027.

Verification
REQ-033 N=8: single-beat packets with sel 0..7, data 0x10+sel, all out_ready=1 -> each channel shows out_valid for exactly one cycle with matching data, one cycle after acceptance.
REQ-034 4-beat packet to channel 5 with in_sel toggling to 2 on beats 2-4 -> all 4 beats appear on channel 5, busy=1 from the cycle after beat 1 until the cycle after beat 4.
REQ-035 out_ready[3]=0, two beats to channel 3 -> first is held, in_ready=0 on the second until out_ready[3]=1, then back-to-back transfer with no loss.
REQ-036 N=6, SELW=3, sel=7 two-beat packet -> in_ready=1, no out_valid on any channel; err=1 with DEMUX_1XN_ERR_EN, 0 without.
REQ-037 rst pulsed mid-packet in LOCK with channel 1 holding a beat -> out_valid=0, busy=0 immediately; next beat routes by its own in_sel.
REQ-038 Channel 0 stalled while beats stream to channel 4 -> channel 4 runs at full rate, channel 0 contents unchanged.
